trans_traffic_gen: RTL

Synthesizable, parametrised traffic source and sink for the PCIe transaction-path FIFO chain: main FIFO, then VC0/VC1 FIFOs, then D0/D1 output FIFOs. It generates the reset/init handshake toward the logic master. It then pushes a programmable number of {VC, dest, data} packets, honouring the main-FIFO pause, and pops the destination FIFOs until they are drained. It replaces hand-written stimulus so the same sequence runs on both the conductual and synthesized datapaths.

---
 rtl/trans_traffic_gen.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/trans_traffic_gen.sv
// Traffic source/sink for the PCIe transaction FIFO chain: init handshake,
// programmable packet push toward the main FIFO, and draining of the destination FIFOs.
module trans_traffic_gen #(
  parameter int          DATA_W      = 4,
  parameter int          VC_W        = 1,
  parameter int          DEST_W      = 1,
  parameter int          INIT_CYCLES = 1,
  parameter int          GAP_CYCLES  = 6,
  parameter logic [15:0] SEED        = 16'hACE1
) (
  input  logic                            clk,
  input  logic                            reset_L,
  input  logic                            start,
  input  logic                            mode,
  input  logic [15:0]                     num_words,
  input  logic                            pop_en,
  input  logic                            pausa,
  input  logic [2**DEST_W-1:0]            empty,
  output logic                            init,
  output logic                            push,
  output logic [VC_W+DEST_W+DATA_W-1:0]   data_out,
  output logic [2**DEST_W-1:0]            pop,
  output logic [15:0]                     sent_count,
  output logic                            busy,
  output logic                            done
);

  localparam int          PKT_W     = VC_W + DEST_W + DATA_W;
  localparam logic [15:0] LFSR_MASK = 16'hB400;
  localparam logic [15:0] INIT_LAST = 16'((INIT_CYCLES > 1) ? INIT_CYCLES - 1 : 0);
  localparam logic [15:0] GAP_LAST  = 16'((GAP_CYCLES > 1) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_GAP,
    S_SEND,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t            state;
  state_t            after_gap;
  logic              start_q;
  logic              mode_q;
  logic [15:0]       num_q;
  logic [15:0]       lfsr;
  logic [15:0]       lfsr_step;
  logic [15:0]       phase_cnt;
  logic              start_rise;
  logic              can_push;
  logic              last_push;
  logic [PKT_W+15:0] idx_ext;
  logic [PKT_W+15:0] lfsr_ext;
  logic [PKT_W-1:0]  next_word;

  assign start_rise = start & ~start_q;
  assign can_push   = ~pausa && (sent_count < num_q);
  assign last_push  = ((sent_count + 16'd1) == num_q);
  assign after_gap  = (num_q == 16'd0) ? S_DRAIN : S_SEND;

  // Zero-extend before slicing so any PKT_W width picks the low bits cleanly.
  assign idx_ext   = {{PKT_W{1'b0}}, sent_count};
  assign lfsr_ext  = {{PKT_W{1'b0}}, lfsr};
  assign next_word = mode_q ? lfsr_ext[PKT_W-1:0] : idx_ext[PKT_W-1:0];
  assign lfsr_step = lfsr[0] ? ((lfsr >> 1) ^ LFSR_MASK) : (lfsr >> 1);

  always_ff @(posedge clk) begin
    if (!reset_L) begin
      state      <= S_IDLE;
      start_q    <= 1'b0;
      mode_q     <= 1'b0;
      num_q      <= 16'd0;
      lfsr       <= SEED;
      phase_cnt  <= 16'd0;
      init       <= 1'b0;
      push       <= 1'b0;
      data_out   <= '0;
      pop        <= '0;
      sent_count <= 16'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      start_q <= start;
      push    <= 1'b0;
      pop     <= '0;
      case (state)
        S_IDLE: begin
          if (start_rise) begin
            state      <= S_INIT;
            mode_q     <= mode;
            num_q      <= num_words;
            sent_count <= 16'd0;
            lfsr       <= SEED;
            data_out   <= '0;
            phase_cnt  <= 16'd0;
            init       <= 1'b1;
            busy       <= 1'b1;
            done       <= 1'b0;
          end
        end
        S_INIT: begin
          if (phase_cnt == INIT_LAST) begin
            init      <= 1'b0;
            phase_cnt <= 16'd0;
            state     <= (GAP_CYCLES == 0) ? after_gap : S_GAP;
          end else begin
            phase_cnt <= phase_cnt + 16'd1;
          end
        end
        S_GAP: begin
          if (phase_cnt == GAP_LAST) begin
            phase_cnt <= 16'd0;
            state     <= after_gap;
          end else begin
            phase_cnt <= phase_cnt + 16'd1;
          end
        end
        S_SEND: begin
          if (pop_en) pop <= ~empty;
          // Pattern and LFSR only advance on an accepted push, so a pause never skips a word.
          if (can_push) begin
            push       <= 1'b1;
            data_out   <= next_word;
            sent_count <= sent_count + 16'd1;
            lfsr       <= lfsr_step;
            if (last_push) state <= S_DRAIN;
          end else if (sent_count >= num_q) begin
            state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if ((&empty) && (pop == '0)) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            pop <= ~empty;
          end
        end
        S_DONE: begin
          if (!start) begin
            state <= S_IDLE;
            done  <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
